multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//  Multi-cycle control sequencer for the RV32 core datapath.
//  - Drives fetch, decode, execute, memory and writeback per instruction.
//  - Produces alu_src for the immediate/operand mux and PC/regfile/memory strobes.
//  - Handshakes with the instruction and data memories; faults on a timeout.
// PARAMETERS
//  MEM_TIMEOUT_CYCLES  16  max wait cycles for imem/dmem ack; 0 = timeout disabled
//  CNT_W               32  width of retired-instruction counter
// PORTS
//  clk        in   1      system clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  opcode     in   7      instruction[6:0] from IR; sampled only in DECODE
//  zero_flag  in   1      ALU zero result, used in EXEC for beq
//  imem_req   out  1      instruction fetch request
//  imem_ack   in   1      instruction valid / fetch done
//  dmem_req   out  1      data memory request
//  dmem_we    out  1      data memory write enable (sw)
//  dmem_ack   in   1      data access done
//  ir_write   out  1      load IR from imem
//  pc_write   out  1      update PC
//  pc_src     out  2      00 pc+4, 01 branch target, 10 jal target, 11 trap vector
//  alu_src    out  1      1 = immediate operand, 0 = rs2
//  reg_write  out  1      regfile write enable
//  wb_sel     out  2      00 ALU, 01 memory data, 10 pc+4
//  state      out  3      current state encoding, for debug
//  fault      out  1      sticky fault flag
//  retired    out  CNT_W  count of completed instructions
// BEHAVIOUR
//  - States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6, FAULT=7.
//  - State, latched opcode, timeout counter and retired counter are registers.
//    All other outputs decode combinationally from state, latched opcode and acks.
//  - Reset (rst_n low, any cycle): state=IDLE, retired=0, timeout count=0.
//    All outputs are 0. Reset mid-transaction drops req at once; late acks are ignored.
//  - IDLE: all outputs 0; goes to FETCH on the next edge.
//  - FETCH: imem_req=1 until ack is sampled.
//    On the ack cycle: ir_write=1, pc_write=1, pc_src=00; next state DECODE.
//  - DECODE: 1 cycle; latch opcode.
//    Legal opcodes: 0110011 R, 0010011 addi, 0000011 lw, 0100011 sw, 1100011 beq, 1101111 jal.
//    Legal -> EXEC; illegal -> FAULT (or TRAP, see CONFIGURATION).
//  - EXEC: alu_src=1 for addi/lw/sw, 0 otherwise.
//    R/addi -> WB. lw/sw -> MEM.
//    beq: pc_write=zero_flag, pc_src=01 -> FETCH.
//    jal: pc_write=1, pc_src=10, reg_write=1, wb_sel=10 -> FETCH.
//  - MEM: dmem_req=1, dmem_we=(sw), alu_src=1 held.
//    On ack: sw -> FETCH, lw -> WB.
//  - WB: reg_write=1; wb_sel=01 for lw, 00 otherwise; alu_src held from EXEC -> FETCH.
//  - Handshake:
//    - req is held high until ack is seen high at a rising edge; req is low in the next state.
//    - An ack while req is low is ignored.
//    - An ack and the timeout firing on the same cycle: the ack wins.
//  - Timeout:
//    - Counter clears on entry to FETCH/MEM and increments on each req-high cycle without ack.
//    - If the count reaches MEM_TIMEOUT_CYCLES -> FAULT.
//  - FAULT: all controls 0, fault=1; held until reset.
//  - retired increments on each transition into FETCH from EXEC/MEM/WB/TRAP.
//    It wraps modulo 2^CNT_W.
//  - Latency, with acks in the first request cycle:
//    - R/addi: 4 cycles.
//    - lw: 5 cycles.
//    - sw: 4 cycles.
//    - beq/jal: 3 cycles.
// CONFIGURATION
//  ILLEGAL_OPCODE_TRAP_EN defined:
//    - Illegal opcode in DECODE -> TRAP for 1 cycle.
//    - TRAP drives pc_write=1, pc_src=11, then FETCH; counts as retired; fault stays 0.
//  ILLEGAL_OPCODE_TRAP_EN undefined:
//    - TRAP is unreachable; an illegal opcode -> FAULT.
//    - pc_src never equals 11.
// TESTING
//  1. addi (0010011), both acks immediate -> IDLE,FETCH,DECODE,EXEC,WB,FETCH.
//     alu_src=1 in EXEC/WB, reg_write=1 in WB only, retired 0->1.
//  2. lw, dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0.
//     WB asserts wb_sel=01, reg_write=1.
//  3. beq with zero_flag=1 then 0 -> pc_write=1/pc_src=01 in the first EXEC, pc_write=0 in the second.
//     Both return to FETCH.
//  4. imem_ack withheld, MEM_TIMEOUT_CYCLES=16 -> FAULT after 16 req cycles.
//     fault=1, all strobes 0; ack arriving later is ignored.
//  5. Opcode 1111111 -> FAULT (macro off).
//     With macro on: TRAP with pc_src=11, then FETCH, retired +1.
//  6. rst_n pulled low mid-MEM of sw -> dmem_req drops immediately, state=IDLE, retired=0.
//     Restarts at FETCH after release.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control sequencer for the RV32 datapath: fetch/decode/exec/mem/wb with memory timeout fault.
// Optional: define ILLEGAL_OPCODE_TRAP_EN to route illegal opcodes to a one-cycle TRAP instead of FAULT.
module multicycle_control_fsm #(
  parameter int unsigned MEM_TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W              = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             zero_flag,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             alu_src,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic [2:0]       state,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd6;
  localparam logic [2:0] S_FAULT  = 3'd7;

  localparam logic [6:0] OPC_R    = 7'b0110011;
  localparam logic [6:0] OPC_ADDI = 7'b0010011;
  localparam logic [6:0] OPC_LW   = 7'b0000011;
  localparam logic [6:0] OPC_SW   = 7'b0100011;
  localparam logic [6:0] OPC_BEQ  = 7'b1100011;
  localparam logic [6:0] OPC_JAL  = 7'b1101111;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JAL    = 2'b10;
  localparam logic [1:0] PC_TRAP   = 2'b11;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  // Counter must hold the limit value itself; a zero limit disables the check.
  localparam int unsigned     TMO_W     = (MEM_TIMEOUT_CYCLES < 1) ? 1 : $clog2(MEM_TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(MEM_TIMEOUT_CYCLES);
  localparam bit              TMO_EN    = (MEM_TIMEOUT_CYCLES != 0);

  logic [2:0]       state_q, state_d;
  logic [6:0]       opcode_q, opcode_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic [TMO_W-1:0] tmo_inc;
  logic             tmo_hit;
  logic             opc_legal;
  logic             is_r, is_addi, is_lw, is_sw, is_beq, is_jal;
  logic             uses_imm;

  // Class decode of the latched opcode, used from EXEC onwards
  always_comb begin
    is_r     = (opcode_q == OPC_R);
    is_addi  = (opcode_q == OPC_ADDI);
    is_lw    = (opcode_q == OPC_LW);
    is_sw    = (opcode_q == OPC_SW);
    is_beq   = (opcode_q == OPC_BEQ);
    is_jal   = (opcode_q == OPC_JAL);
    uses_imm = is_addi | is_lw | is_sw;
  end

  // Legality check on the live IR opcode during DECODE
  always_comb begin
    opc_legal = (opcode == OPC_R)  || (opcode == OPC_ADDI) ||
                (opcode == OPC_LW) || (opcode == OPC_SW)   ||
                (opcode == OPC_BEQ) || (opcode == OPC_JAL);
  end

  always_comb begin
    tmo_inc = tmo_cnt_q + TMO_W'(1);
    tmo_hit = TMO_EN && (tmo_inc == TMO_LIMIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      opcode_q  <= 7'd0;
      tmo_cnt_q <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      tmo_cnt_q <= tmo_cnt_d;
      retired_q <= retired_d;
    end
  end

  // Next-state; the timeout counter is zero everywhere except while waiting in FETCH/MEM
  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    tmo_cnt_d = '0;
    retired_d = retired_q;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        if (imem_ack) begin
          state_d = S_DECODE;
        end else if (tmo_hit) begin
          state_d = S_FAULT;
        end else begin
          tmo_cnt_d = tmo_inc;
        end
      end

      S_DECODE: begin
        opcode_d = opcode;
        if (opc_legal) begin
          state_d = S_EXEC;
        end else begin
`ifdef ILLEGAL_OPCODE_TRAP_EN
          state_d = S_TRAP;
`else
          state_d = S_FAULT;
`endif
        end
      end

      S_EXEC: begin
        if (is_r || is_addi) begin
          state_d = S_WB;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else if (is_beq || is_jal) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_FAULT;
        end
      end

      S_MEM: begin
        if (dmem_ack) begin
          state_d = is_sw ? S_FETCH : S_WB;
        end else if (tmo_hit) begin
          state_d = S_FAULT;
        end else begin
          tmo_cnt_d = tmo_inc;
        end
      end

      S_WB: state_d = S_FETCH;

      S_TRAP: begin
`ifdef ILLEGAL_OPCODE_TRAP_EN
        state_d = S_FETCH;
`else
        state_d = S_FAULT;
`endif
      end

      S_FAULT: state_d = S_FAULT;

      default: state_d = S_FAULT;
    endcase

    // An instruction retires when control returns to FETCH from a completing state
    if ((state_d == S_FETCH) &&
        ((state_q == S_EXEC) || (state_q == S_MEM) ||
         (state_q == S_WB)   || (state_q == S_TRAP))) begin
      retired_d = retired_q + CNT_W'(1);
    end
  end

  // Control strobes decode from state, latched opcode and the acks
  always_comb begin
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PC_PLUS4;
    alu_src   = 1'b0;
    reg_write = 1'b0;
    wb_sel    = WB_ALU;

    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          pc_src   = PC_PLUS4;
        end
      end

      S_EXEC: begin
        alu_src = uses_imm;
        if (is_beq) begin
          pc_write = zero_flag;
          pc_src   = PC_BRANCH;
        end else if (is_jal) begin
          pc_write  = 1'b1;
          pc_src    = PC_JAL;
          reg_write = 1'b1;
          wb_sel    = WB_PC4;
        end
      end

      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_sw;
        alu_src  = 1'b1;
      end

      S_WB: begin
        reg_write = 1'b1;
        wb_sel    = is_lw ? WB_MEM : WB_ALU;
        alu_src   = uses_imm;
      end

`ifdef ILLEGAL_OPCODE_TRAP_EN
      S_TRAP: begin
        pc_write = 1'b1;
        pc_src   = PC_TRAP;
      end
`endif

      default: ;
    endcase
  end

  assign state   = state_q;
  assign fault   = (state_q == S_FAULT);
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed self-checking bench for multicycle_control_fsm (default timeout of 16 cycles).
module tb_multicycle_control_fsm;

  localparam logic [6:0] OPC_R    = 7'b0110011;
  localparam logic [6:0] OPC_ADDI = 7'b0010011;
  localparam logic [6:0] OPC_LW   = 7'b0000011;
  localparam logic [6:0] OPC_SW   = 7'b0100011;
  localparam logic [6:0] OPC_BEQ  = 7'b1100011;
  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_BAD  = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  opcode;
  logic        zero_flag;
  logic        imem_req, imem_ack;
  logic        dmem_req, dmem_we, dmem_ack;
  logic        ir_write, pc_write, alu_src, reg_write, fault;
  logic [1:0]  pc_src, wb_sel;
  logic [2:0]  state;
  logic [31:0] retired;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_control_fsm #(
    .MEM_TIMEOUT_CYCLES(16),
    .CNT_W             (32)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .opcode   (opcode),
    .zero_flag(zero_flag),
    .imem_req (imem_req),
    .imem_ack (imem_ack),
    .dmem_req (dmem_req),
    .dmem_we  (dmem_we),
    .dmem_ack (dmem_ack),
    .ir_write (ir_write),
    .pc_write (pc_write),
    .pc_src   (pc_src),
    .alu_src  (alu_src),
    .reg_write(reg_write),
    .wb_sel   (wb_sel),
    .state    (state),
    .fault    (fault),
    .retired  (retired)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Resets, releases, and returns positioned in the first FETCH cycle
  task automatic do_reset();
    rst_n     = 1'b0;
    imem_ack  = 1'b0;
    dmem_ack  = 1'b0;
    zero_flag = 1'b0;
    opcode    = 7'd0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // From FETCH: immediate imem ack, decode opc, return in the state after DECODE
  task automatic fetch_decode(input logic [6:0] opc);
    check_eq("fetch_state", 32'(state), 32'd1);
    imem_ack = 1'b1;
    #1;
    check_eq("fetch_ir_write", 32'(ir_write), 32'd1);
    check_eq("fetch_pc_write", 32'(pc_write), 32'd1);
    check_eq("fetch_pc_src", 32'(pc_src), 32'd0);
    tick();
    imem_ack = 1'b0;
    opcode   = opc;
    #1;
    check_eq("decode_state", 32'(state), 32'd2);
    check_eq("decode_imem_req", 32'(imem_req), 32'd0);
    tick();
    opcode = 7'd0;
    #1;
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    opcode    = 7'd0;
    zero_flag = 1'b0;
    imem_ack  = 1'b0;
    dmem_ack  = 1'b0;
    tick();
    tick();
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_retired", retired, 32'd0);
    check_eq("rst_imem_req", 32'(imem_req), 32'd0);
    check_eq("rst_dmem_req", 32'(dmem_req), 32'd0);
    check_eq("rst_fault", 32'(fault), 32'd0);

    rst_n = 1'b1;
    #1;
    check_eq("idle_state", 32'(state), 32'd0);
    check_eq("idle_imem_req", 32'(imem_req), 32'd0);
    tick();
    check_eq("fetch_req", 32'(imem_req), 32'd1);
    check_eq("fetch_noack_irw", 32'(ir_write), 32'd0);

    // addi, both acks immediate
    fetch_decode(OPC_ADDI);
    check_eq("addi_exec_state", 32'(state), 32'd3);
    check_eq("addi_exec_alu_src", 32'(alu_src), 32'd1);
    check_eq("addi_exec_reg_write", 32'(reg_write), 32'd0);
    tick();
    check_eq("addi_wb_state", 32'(state), 32'd5);
    check_eq("addi_wb_reg_write", 32'(reg_write), 32'd1);
    check_eq("addi_wb_alu_src", 32'(alu_src), 32'd1);
    check_eq("addi_wb_sel", 32'(wb_sel), 32'd0);
    check_eq("addi_wb_retired", retired, 32'd0);
    tick();
    check_eq("addi_ret_state", 32'(state), 32'd1);
    check_eq("addi_retired", retired, 32'd1);
    check_eq("addi_ret_reg_write", 32'(reg_write), 32'd0);

    // lw with dmem ack arriving on the 4th request cycle
    fetch_decode(OPC_LW);
    check_eq("lw_exec_alu_src", 32'(alu_src), 32'd1);
    check_eq("lw_exec_dmem_req", 32'(dmem_req), 32'd0);
    tick();
    check_eq("lw_mem_state", 32'(state), 32'd4);
    check_eq("lw_mem_we", 32'(dmem_we), 32'd0);
    check_eq("lw_mem_alu_src", 32'(alu_src), 32'd1);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      if (dmem_req) n++;
      tick();
    end
    dmem_ack = 1'b1;
    #1;
    if (dmem_req) n++;
    check_eq("lw_mem_wait_state", 32'(state), 32'd4);
    tick();
    dmem_ack = 1'b0;
    #1;
    check_eq("lw_req_cycles", 32'(n), 32'd4);
    check_eq("lw_wb_state", 32'(state), 32'd5);
    check_eq("lw_wb_sel", 32'(wb_sel), 32'd1);
    check_eq("lw_wb_reg_write", 32'(reg_write), 32'd1);
    check_eq("lw_wb_dmem_req", 32'(dmem_req), 32'd0);
    tick();
    check_eq("lw_retired", retired, 32'd2);

    // sw, immediate ack
    fetch_decode(OPC_SW);
    tick();
    dmem_ack = 1'b1;
    #1;
    check_eq("sw_mem_req", 32'(dmem_req), 32'd1);
    check_eq("sw_mem_we", 32'(dmem_we), 32'd1);
    check_eq("sw_mem_alu_src", 32'(alu_src), 32'd1);
    tick();
    dmem_ack = 1'b0;
    #1;
    check_eq("sw_ret_state", 32'(state), 32'd1);
    check_eq("sw_retired", retired, 32'd3);
    check_eq("sw_ret_dmem_req", 32'(dmem_req), 32'd0);

    // beq taken then not taken
    fetch_decode(OPC_BEQ);
    zero_flag = 1'b1;
    #1;
    check_eq("beq_t_pc_write", 32'(pc_write), 32'd1);
    check_eq("beq_t_pc_src", 32'(pc_src), 32'd1);
    check_eq("beq_t_alu_src", 32'(alu_src), 32'd0);
    tick();
    zero_flag = 1'b0;
    check_eq("beq_t_state", 32'(state), 32'd1);
    check_eq("beq_t_retired", retired, 32'd4);
    fetch_decode(OPC_BEQ);
    check_eq("beq_n_pc_write", 32'(pc_write), 32'd0);
    check_eq("beq_n_pc_src", 32'(pc_src), 32'd1);
    tick();
    check_eq("beq_n_state", 32'(state), 32'd1);
    check_eq("beq_n_retired", retired, 32'd5);

    // jal
    fetch_decode(OPC_JAL);
    check_eq("jal_pc_write", 32'(pc_write), 32'd1);
    check_eq("jal_pc_src", 32'(pc_src), 32'd2);
    check_eq("jal_reg_write", 32'(reg_write), 32'd1);
    check_eq("jal_wb_sel", 32'(wb_sel), 32'd2);
    tick();
    check_eq("jal_retired", retired, 32'd6);

    // R-type with stray acks while no request is outstanding
    fetch_decode(OPC_R);
    imem_ack = 1'b1;
    dmem_ack = 1'b1;
    #1;
    check_eq("r_exec_state", 32'(state), 32'd3);
    check_eq("r_exec_alu_src", 32'(alu_src), 32'd0);
    check_eq("r_stray_ir_write", 32'(ir_write), 32'd0);
    check_eq("r_stray_dmem_req", 32'(dmem_req), 32'd0);
    tick();
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    #1;
    check_eq("r_wb_state", 32'(state), 32'd5);
    check_eq("r_wb_sel", 32'(wb_sel), 32'd0);
    check_eq("r_wb_alu_src", 32'(alu_src), 32'd0);
    tick();
    check_eq("r_retired", retired, 32'd7);

    // Reset asserted mid-MEM of sw, with a late ack held during reset
    fetch_decode(OPC_SW);
    tick();
    check_eq("rstmid_mem_req", 32'(dmem_req), 32'd1);
    dmem_ack = 1'b1;
    rst_n    = 1'b0;
    #1;
    check_eq("rstmid_dmem_req", 32'(dmem_req), 32'd0);
    check_eq("rstmid_state", 32'(state), 32'd0);
    check_eq("rstmid_retired", retired, 32'd0);
    tick();
    check_eq("rstmid_hold_state", 32'(state), 32'd0);
    rst_n    = 1'b1;
    dmem_ack = 1'b0;
    tick();
    check_eq("rstmid_restart_state", 32'(state), 32'd1);
    check_eq("rstmid_restart_req", 32'(imem_req), 32'd1);

    // Illegal opcode
    fetch_decode(OPC_BAD);
`ifdef ILLEGAL_OPCODE_TRAP_EN
    check_eq("ill_trap_state", 32'(state), 32'd6);
    check_eq("ill_trap_pc_write", 32'(pc_write), 32'd1);
    check_eq("ill_trap_pc_src", 32'(pc_src), 32'd3);
    check_eq("ill_trap_fault", 32'(fault), 32'd0);
    tick();
    check_eq("ill_trap_ret_state", 32'(state), 32'd1);
    check_eq("ill_trap_retired", retired, 32'd1);
`else
    check_eq("ill_fault_state", 32'(state), 32'd7);
    check_eq("ill_fault_flag", 32'(fault), 32'd1);
    check_eq("ill_fault_pc_write", 32'(pc_write), 32'd0);
    check_eq("ill_fault_pc_src", 32'(pc_src), 32'd0);
    tick();
    check_eq("ill_fault_hold", 32'(state), 32'd7);
`endif
    do_reset();

    // imem ack withheld: FAULT after 16 request cycles
    n = 0;
    while ((state == 3'd1) && (n < 40)) begin
      if (imem_req) n++;
      tick();
    end
    check_eq("tmo_req_cycles", 32'(n), 32'd16);
    check_eq("tmo_state", 32'(state), 32'd7);
    check_eq("tmo_fault", 32'(fault), 32'd1);
    check_eq("tmo_imem_req", 32'(imem_req), 32'd0);
    check_eq("tmo_pc_write", 32'(pc_write), 32'd0);
    check_eq("tmo_reg_write", 32'(reg_write), 32'd0);
    imem_ack = 1'b1;
    #1;
    check_eq("tmo_late_ack_irw", 32'(ir_write), 32'd0);
    tick();
    tick();
    check_eq("tmo_late_ack_state", 32'(state), 32'd7);
    imem_ack = 1'b0;

    // Ack on the 16th request cycle beats the timeout
    do_reset();
    for (int i = 0; i < 15; i++) tick();
    check_eq("race_pre_state", 32'(state), 32'd1);
    imem_ack = 1'b1;
    #1;
    check_eq("race_ir_write", 32'(ir_write), 32'd1);
    tick();
    imem_ack = 1'b0;
    #1;
    check_eq("race_state", 32'(state), 32'd2);
    check_eq("race_fault", 32'(fault), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
